// File: rtl/seq_mul_datapath.sv
// Shift-add datapath and iteration counter for the sequential multiplier.
// Latency: load captured at edge 0, WIDTH steps at edges 1..WIDTH, product/done visible after edge WIDTH.
// Backpressure: none; dropping run pauses the operation with all state held, no flow control beyond that.
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   reset        - synchronous active-high reset, highest priority
//   load         - operand capture strobe (also starts the run-enable generator)
//   run          - step enable from the run-enable generator
//   multiplicand - operand M, sampled when load=1
//   multiplier   - operand Q, sampled when load=1
//   tc           - combinational terminal count back to the run-enable generator
//   product      - registered 2*WIDTH-bit result, held until the next completion
//   done         - registered one-cycle completion pulse
//   busy         - registered, high from load until the final step

module seq_mul_datapath #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 tc,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Working registers: {c_q, a_q} is the partial-sum accumulator,
    // qr_q holds the remaining multiplier bits and fills with low product bits.
    logic [WIDTH-1:0]   m_q,       m_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic               c_q,       c_d;
    logic [WIDTH-1:0]   qr_q,      qr_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q,    done_d;
    logic               busy_q,    busy_d;

    logic               step;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;

    // load outranks run, so a cycle carrying both is a capture, never a step.
    assign step = run & ~load;

    // Combinational so the generator sees it on the same edge as the last step.
    assign tc = step & (cnt_q == LAST_CNT);

    always_comb begin
        // Full WIDTH+1-bit add keeps the carry of (2^W-1)+(2^W-1).
        // C is always zero entering a step because the shift clears it.
        sum     = qr_q[0] ? ({c_q, a_q} + {1'b0, m_q}) : {c_q, a_q};
        // Right shift of {C,A,Q}: the consumed Q[0] drops off the bottom,
        // C shifts into A's MSB and a zero refills C.
        shifted = {sum, qr_q[WIDTH-1:1]};
    end

    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        c_d       = c_q;
        qr_d      = qr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        if (load) begin
            m_d    = multiplicand;
            qr_d   = multiplier;
            a_d    = '0;
            c_d    = 1'b0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (run) begin
            a_d  = shifted[2*WIDTH-1:WIDTH];
            qr_d = shifted[WIDTH-1:0];
            c_d  = 1'b0;
            if (tc) begin
                // Final step: publish the post-shift value and wrap the counter.
                cnt_d     = '0;
                product_d = shifted;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q       <= '0;
            a_q       <= '0;
            c_q       <= 1'b0;
            qr_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            c_q       <= c_d;
            qr_q      <= qr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_seq_mul_datapath.sv
// Bench for seq_mul_datapath: directed operand pairs with hand-computed products.
// Expected products are queued at load time; a negedge monitor pops on every done.
// tc is checked every cycle against a small step-count model.

module tb_seq_mul_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        run;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        tc;
    logic [15:0] product;
    logic        done;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    int          cyc           = 0;
    int          done_cnt      = 0;
    int          last_done_cyc = 0;
    int          tc_cnt        = 0;
    int          mcnt          = 0;

    seq_mul_datapath #(.WIDTH(8), .CW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .run          (run),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .tc           (tc),
        .product      (product),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest queued product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: product 0x%0h, no result expected (cycle %0d)", product, cyc);
            end else begin
                check("product_at_done", 32'(product), 32'(exp_q.pop_front()));
                check("busy_at_done", 32'(busy), 0);
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic tick(input logic ld, input logic rn, input logic [7:0] m, input logic [7:0] q);
        logic exp_tc;
        load         = ld;
        run          = rn;
        multiplicand = m;
        multiplier   = q;
        exp_tc       = rn & ~ld & (mcnt == 7);
        @(negedge clk);
        check("tc", 32'(tc), 32'(exp_tc));
        if (tc === 1'b1) tc_cnt++;
        if (ld) mcnt = 0;
        else if (rn) mcnt = (mcnt + 1) % 8;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp_p);
        exp_q.push_back(exp_p);
        tick(1'b1, 1'b0, m, q);
        check("busy_after_load", 32'(busy), 1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 8'd0, 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        int tc0;
        int d1;
        reset        = 1'b1;
        load         = 1'b0;
        run          = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_product", 32'(product), 0);
        check("reset_done", 32'(done), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tc", 32'(tc), 0);

        // 1: 13 x 11 = 143, tc exactly once, done/busy timing
        tc0 = tc_cnt;
        start_op(8'd13, 8'd11, 16'h008F);
        steps(8);
        check("t1_done_after_edge8", 32'(done), 1);
        check("t1_busy_falls", 32'(busy), 0);
        idle(1);
        check("t1_done_one_cycle", 32'(done), 0);
        check("t1_product_held", 32'(product), 32'h008F);
        check("t1_tc_once", 32'(tc_cnt - tc0), 1);

        // 2: carry at the extreme, then zero multiplicand
        start_op(8'd255, 8'd255, 16'hFE01);
        steps(8);
        idle(1);
        start_op(8'd0, 8'd200, 16'h0000);
        steps(8);
        idle(1);

        // 3: restart after 3 steps; only the second op completes
        tc0 = tc_cnt;
        tick(1'b1, 1'b0, 8'd7, 8'd9);
        steps(3);
        start_op(8'd6, 8'd5, 16'h001E);
        steps(8);
        idle(1);
        check("t3_tc_once", 32'(tc_cnt - tc0), 1);

        // 4: reset during step 4 abandons the op
        tick(1'b1, 1'b0, 8'd12, 8'd12);
        steps(3);
        run   = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        mcnt  = 0;
        check("t4_reset_product", 32'(product), 0);
        check("t4_reset_done", 32'(done), 0);
        check("t4_reset_busy", 32'(busy), 0);
        idle(2);
        start_op(8'd3, 8'd4, 16'h000C);
        steps(8);
        idle(1);

        // 5: pause of 5 cycles mid-operation
        start_op(8'd100, 8'd3, 16'h012C);
        steps(4);
        idle(5);
        check("t5_busy_paused", 32'(busy), 1);
        check("t5_no_early_done", 32'(done), 0);
        steps(4);
        idle(1);

        // 6: back-to-back, second load in the done cycle
        start_op(8'd2, 8'd3, 16'h0006);
        steps(8);
        start_op(8'd10, 8'd10, 16'h0064);
        d1 = last_done_cyc;
        check("t6_first_held", 32'(product), 32'h0006);
        for (int i = 0; i < 8; i++) begin
            steps(1);
            if (i < 7) check("t6_first_held", 32'(product), 32'h0006);
        end
        idle(1);
        check("t6_done_spacing", 32'(last_done_cyc - d1), 9);

        check("all_results_seen", 32'(exp_q.size()), 0);
        check("done_count", 32'(done_cnt), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mul_datapath.md
Name: seq_mul_datapath

Overview:
Shift-add datapath and iteration counter for the sequential multiplier. It consumes the run-enable level `q` from the run-enable generator and returns the terminal-count `tc` that clears that generator. On `load` it captures the operands. It then performs one shift-add step per clock while `run` is high, and publishes a registered 2*WIDTH-bit product with a one-cycle `done` pulse.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- CW, 4, counter width; must satisfy 2^CW ≥ WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  operand capture strobe; same pulse that drives the generator's start.
- run  input  1  step enable; driven by the run-enable generator output q.
- multiplicand  input  WIDTH  operand M, sampled when load=1.
- multiplier  input  WIDTH  operand Q, sampled when load=1.
- tc  output  1  terminal count; combinational; feeds generator tc input.
- product  output  2*WIDTH  registered result, held until the next completion.
- done  output  1  registered one-cycle completion pulse.
- busy  output  1  registered; high from load until the final step.

Behaviour:
- Internal state: M_r (WIDTH), A (WIDTH), C (1), Q_r (WIDTH), cnt (CW).
- Reset (reset=1 at an edge) has priority over everything:
  - A, C, Q_r, M_r, cnt, product, done, busy all go to 0.
  - Reset mid-operation abandons the operation; no done is produced.
- Load (load=1, no reset) has priority over run:
  - M_r<=multiplicand, Q_r<=multiplier, A<=0, C<=0, cnt<=0, busy<=1, done<=0.
  - Load during an active operation restarts cleanly with the new operands.
- Step (run=1, load=0, reset=0), one per edge:
  - {C,A} = Q_r[0] ? A+M_r : {1'b0,A}, computed WIDTH+1 bits wide with no truncation.
  - {C,A,Q_r} <= ({C,A,Q_r} of that sum) >> 1, with C<=0 after the shift.
  - cnt <= cnt+1, wrapping to 0 on the terminal step.
- Terminal count:
  - tc = run & ~load & (cnt == WIDTH-1).
  - tc is combinational so the generator samples it on the same edge as the last step and drops run afterwards.
  - tc must not assert outside a step cycle.
- Completion, at the edge of the step where tc=1:
  - product <= final {A,Q_r} (post-shift value).
  - done <= 1, busy <= 0.
  - done returns to 0 on the next edge unless another terminal step occurs.
- Timing:
  - load sampled at edge 0; steps at edges 1..WIDTH; done and product visible after edge WIDTH.
  - Latency from load to done is WIDTH+1 edges.
  - Back-to-back: a load in the cycle done is high is legal.
- run=0 with busy=1: state holds; operation pauses and resumes when run returns.
- run=1 with busy=0 (generator misuse): steps still execute on the held state and tc still fires after WIDTH steps. Product and done update accordingly. This is not an error condition.
- Arithmetic: unsigned only. Product is exact for all operands, max (2^WIDTH-1)^2.
- product is never updated except on a terminal step or reset. Idle steps never disturb a valid result.

Test Plan:
1. Reset, then load M=13, Q=11, run high from next cycle → tc high only in the 8th step cycle; done one cycle after edge 8; product=0x008F (143); busy falls with done.
2. Load M=255, Q=255 → product=0xFE01 (65025); verify no carry loss. Then load M=0, Q=200 → product=0x0000, done still pulses once.
3. Load 7×9, then after 3 steps load 6×5 → no done for the first op; done after 8 further steps with product=0x001E (30); tc asserted exactly once.
4. Load 12×12, assert reset at step 4 → all outputs 0 next cycle, no done. Subsequent load 3×4 → product=0x000C.
5. Load 100×3, drop run for 5 cycles mid-operation → state held, tc stays low. After resume, product=0x012C (300), with total step count 8.
6. Back-to-back: load 2×3, then load 10×10 in the done cycle → products 0x0006 then 0x0064, two distinct done pulses 9 cycles apart. The 0x0006 result is held until the second done.
